// File: rtl/mul4_ge_pkg.sv
`default_nettype none
// mul4_ge_pkg: shared types, widths and helpers for the mul4 fitness-scoring stage.
// Rev 1.0
package mul4_ge_pkg;

   localparam int WORD_W    = 16;
   localparam int PROD_W    = 4 * WORD_W;
   localparam int MAX_CASES = 256;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      MUL   = 3'd2,
      SCORE = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         n = n + {6'd0, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul4_golden_mul.sv
`default_nettype none
// mul4_golden_mul: unsigned 32x32->64 radix-2 shift-add multiplier, one multiplier bit per cycle.
// Rev 1.0
module mul4_golden_mul
   import mul4_ge_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [2*WORD_W-1:0]   a_i,
   input  logic [2*WORD_W-1:0]   b_i,
   output logic                  done_o,
   output logic [PROD_W-1:0]     prod_o
);

   localparam int STEP_W = $clog2(2 * WORD_W);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * WORD_W - 1);

   logic                busy_q;
   logic [STEP_W-1:0]   step_q;
   logic [PROD_W-1:0]   acc_q;
   logic [PROD_W-1:0]   mcand_q;
   logic [2*WORD_W-1:0] mplier_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         step_q   <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (start_i) begin
         busy_q   <= 1'b1;
         step_q   <= '0;
         acc_q    <= '0;
         mcand_q  <= {{(PROD_W-2*WORD_W){1'b0}}, a_i};
         mplier_q <= b_i;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         step_q   <= step_q + STEP_W'(1);
         if (step_q == LAST_STEP) begin
            busy_q <= 1'b0;
         end
      end
   end

   // Flags the final step: prod_o is complete on the following cycle.
   assign done_o = busy_q && (step_q == LAST_STEP);
   assign prod_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/mul4_fitness_scorer.sv
`default_nettype none
// mul4_fitness_scorer: scores candidate mul4 outputs bitwise against a golden product over num_cases samples.
// Rev 1.0
module mul4_fitness_scorer
   import mul4_ge_pkg::*;
#(
   parameter int CNT_W   = 9,
   parameter int SCORE_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [CNT_W-1:0]    num_cases_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [WORD_W-1:0]   a1_i,
   input  logic [WORD_W-1:0]   a0_i,
   input  logic [WORD_W-1:0]   b1_i,
   input  logic [WORD_W-1:0]   b0_i,
   input  logic [WORD_W-1:0]   y3_i,
   input  logic [WORD_W-1:0]   y2_i,
   input  logic [WORD_W-1:0]   y1_i,
   input  logic [WORD_W-1:0]   y0_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [SCORE_W-1:0]  score_o,
   output logic [CNT_W-1:0]    perfect_cnt_o
);

   state_t              state_q;
   logic [CNT_W-1:0]    num_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [PROD_W-1:0]   cand_q;
   logic [SCORE_W-1:0]  score_q;
   logic [CNT_W-1:0]    perfect_q;
   logic                in_ready_q;
   logic                busy_q;
   logic                done_q;

   logic                accept;
   logic                mul_done;
   logic [PROD_W-1:0]   golden;
   logic [6:0]          mismatch_bits;
   logic [6:0]          match_bits;
   logic                exact;
   logic                last_case;

   assign accept        = in_valid_i && in_ready_q;
   assign mismatch_bits = popcount64(golden ^ cand_q);
   assign match_bits    = 7'(PROD_W) - mismatch_bits;
   assign exact         = (mismatch_bits == 7'd0);
   assign last_case     = ((cnt_q + CNT_W'(1)) == num_q);

   mul4_golden_mul u_golden (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept),
      .a_i     ({a1_i, a0_i}),
      .b_i     ({b1_i, b0_i}),
      .done_o  (mul_done),
      .prod_o  (golden)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         num_q      <= '0;
         cnt_q      <= '0;
         cand_q     <= '0;
         score_q    <= '0;
         perfect_q  <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  score_q   <= '0;
                  perfect_q <= '0;
                  cnt_q     <= '0;
                  num_q     <= num_cases_i;
                  if (num_cases_i == '0) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     busy_q     <= 1'b0;
                     in_ready_q <= 1'b0;
                  end else begin
                     state_q    <= WAIT;
                     done_q     <= 1'b0;
                     busy_q     <= 1'b1;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            WAIT: begin
               // Operands go straight into the multiplier on this edge; only the candidate is kept here.
               if (accept) begin
                  cand_q     <= {y3_i, y2_i, y1_i, y0_i};
                  in_ready_q <= 1'b0;
                  state_q    <= MUL;
               end
            end
            MUL: begin
               if (mul_done) begin
                  state_q <= SCORE;
               end
            end
            SCORE: begin
               score_q   <= score_q + SCORE_W'(match_bits);
               perfect_q <= perfect_q + CNT_W'(exact);
               cnt_q     <= cnt_q + CNT_W'(1);
               if (last_case) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= WAIT;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o    = in_ready_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign score_o       = score_q;
   assign perfect_cnt_o = perfect_q;

endmodule
`default_nettype wire

// File: tb/tb_mul4_fitness_scorer.sv
`default_nettype none
// tb_mul4_fitness_scorer: directed, table-driven checks of the mul4 fitness scorer.
// Rev 1.0
module tb_mul4_fitness_scorer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  num_cases = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a1 = '0, a0 = '0, b1 = '0, b0 = '0;
   logic [15:0] y3 = '0, y2 = '0, y1 = '0, y0 = '0;
   logic        busy, done;
   logic [15:0] score;
   logic [8:0]  perfect_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] y;
      logic [15:0] exp_score;
      logic [8:0]  exp_perf;
   } vec_t;

   vec_t vecs [7];
   vec_t t5   [4];

   mul4_fitness_scorer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .num_cases_i   (num_cases),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .a1_i          (a1),
      .a0_i          (a0),
      .b1_i          (b1),
      .b0_i          (b0),
      .y3_i          (y3),
      .y2_i          (y2),
      .y1_i          (y1),
      .y0_i          (y0),
      .busy_o        (busy),
      .done_o        (done),
      .score_o       (score),
      .perfect_cnt_o (perfect_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_ops(input vec_t v);
      {a1, a0} = v.a;
      {b1, b0} = v.b;
      {y3, y2, y1, y0} = v.y;
   endtask

   task automatic do_start(input logic [8:0] n);
      @(negedge clk);
      start     = 1'b1;
      num_cases = n;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Leaves the caller at the negedge of the handshake cycle (accept on the next posedge).
   task automatic wait_accept(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Cycle 0 is the handshake cycle; returns the first cycle index in which done is seen.
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (i == 1) in_valid = 1'b0;
         if (done === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic run_one(input vec_t v, input string tag);
      bit ok;
      int cyc;
      set_ops(v);
      in_valid = 1'b1;
      do_start(9'd1);
      wait_accept(ok);
      chk({tag, "_accept"}, 64'(ok), 64'd1);
      wait_done(cyc);
      chk({tag, "_done_cycle"}, 64'(cyc), 64'd34);
      chk({tag, "_score"}, 64'(score), 64'(v.exp_score));
      chk({tag, "_perfect"}, 64'(perfect_cnt), 64'(v.exp_perf));
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin : main
      bit ok;
      int c, last, k;
      bit acc_now;
      bit ready_seen;

      vecs[0] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 16'd64, 9'd1};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,                   16'd32, 9'd0};
      vecs[2] = '{32'd3,         32'd5,         64'd15,                  16'd64, 9'd1};
      vecs[3] = '{32'd0,         32'h1234_5678, 64'd0,                   16'd64, 9'd1};
      vecs[4] = '{32'd2,         32'd3,         64'd7,                   16'd63, 9'd0};
      vecs[5] = '{32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 16'd32, 9'd0};
      vecs[6] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 16'd64, 9'd1};

      t5[0] = '{32'd3,         32'd5,         64'd15,                  16'd0, 9'd0};
      t5[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,                   16'd0, 9'd0};
      t5[2] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 16'd0, 9'd0};
      t5[3] = '{32'hFFFF_FFFF, 32'd1,         64'h0,                   16'd0, 9'd0};

      // Reset held for two edges
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy",     64'(busy),     64'd0);
      chk("rst_done",     64'(done),     64'd0);
      chk("rst_score",    64'(score),    64'd0);
      chk("rst_perfect",  64'(perfect_cnt), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_one(vecs[i], $sformatf("vec%0d", i));
      end

      // Zero-case evaluation completes immediately without asking for samples
      in_valid = 1'b1;
      set_ops(vecs[2]);
      do_start(9'd0);
      chk("zero_done",  64'(done),  64'd1);
      chk("zero_score", 64'(score), 64'd0);
      chk("zero_perf",  64'(perfect_cnt), 64'd0);
      ready_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready === 1'b1) ready_seen = 1'b1;
         @(negedge clk);
      end
      chk("zero_no_ready", 64'(ready_seen), 64'd0);
      chk("zero_done_held", 64'(done), 64'd1);

      // Four samples, in_valid held high, operands advanced after each accept
      set_ops(t5[0]);
      in_valid = 1'b1;
      do_start(9'd4);
      chk("t5_done_dropped", 64'(done), 64'd0);
      c = 0; last = 0; k = 0;
      while (c < 400 && done !== 1'b1) begin
         acc_now = 1'b0;
         if (in_ready === 1'b1) begin
            if (k > 0) chk($sformatf("t5_gap%0d", k), 64'(c - last), 64'd34);
            last    = c;
            k++;
            acc_now = 1'b1;
         end
         @(negedge clk);
         c++;
         if (acc_now && k < 4) set_ops(t5[k]);
      end
      chk("t5_timeout", 64'(c < 400), 64'd1);
      chk("t5_accepts", 64'(k), 64'd4);
      chk("t5_score",   64'(score), 64'd192);
      chk("t5_perfect", 64'(perfect_cnt), 64'd2);
      ready_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready === 1'b1) ready_seen = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("t5_no_extra_accept", 64'(ready_seen), 64'd0);
      chk("t5_score_held", 64'(score), 64'd192);

      // Reset in the middle of a multiply, then a clean evaluation
      set_ops(vecs[1]);
      in_valid = 1'b1;
      do_start(9'd1);
      wait_accept(ok);
      chk("t6_accept", 64'(ok), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t6_in_ready", 64'(in_ready), 64'd0);
      chk("t6_busy",     64'(busy),     64'd0);
      chk("t6_done",     64'(done),     64'd0);
      chk("t6_score",    64'(score),    64'd0);
      chk("t6_perfect",  64'(perfect_cnt), 64'd0);
      repeat (40) @(negedge clk);
      chk("t6_idle_done", 64'(done), 64'd0);
      chk("t6_idle_busy", 64'(busy), 64'd0);
      run_one('{32'd2, 32'd3, 64'd6, 16'd64, 9'd1}, "t6_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
